// File: rtl/snake_motion_engine.sv
// Snake head/body position engine: game-state FSM, per-tick movement, growth, reversal lockout, self-collision.
// Optional build macro SNAKE_WALL_KILL_EN turns grid-edge crossings into collisions instead of wrap-around.
module snake_motion_engine #(
  parameter int GRID_W  = 640,
  parameter int GRID_H  = 480,
  parameter int CW      = 10,
  parameter int MAX_LEN = 8,
  parameter int LW      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            buttons,
  input  logic                  step,
  input  logic                  grow,
  input  logic                  start,
  output logic [MAX_LEN*CW-1:0] pos_x,
  output logic [MAX_LEN*CW-1:0] pos_y,
  output logic [LW-1:0]         length,
  output logic [1:0]            state,
  output logic                  collision
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_DOWN, DIR_RIGHT, DIR_UP} dir_t;

  localparam logic [CW-1:0]        HOME_X  = CW'(GRID_W / 2);
  localparam logic [CW-1:0]        HOME_Y  = CW'(GRID_H / 2);
  localparam logic [CW-1:0]        LAST_X  = CW'(GRID_W - 1);
  localparam logic [CW-1:0]        LAST_Y  = CW'(GRID_H - 1);
  localparam logic signed [CW:0]   LIM_X   = (CW+1)'(GRID_W);
  localparam logic signed [CW:0]   LIM_Y   = (CW+1)'(GRID_H);
  localparam logic signed [CW:0]   VEL_POS = (CW+1)'(1);
  localparam logic signed [CW:0]   VEL_NEG = -VEL_POS;
  localparam logic [LW-1:0]        LEN_ONE = LW'(1);
  localparam logic [LW-1:0]        LEN_MAX = LW'(MAX_LEN);

  state_t             state_reg, state_next;
  dir_t               dir_reg, pend_dir_reg, req_dir, pend_next;
  logic               grow_pend_reg;
  logic               collision_reg;
  logic [LW-1:0]      len_reg, len_next;
  logic [CW-1:0]      slot_x_reg [MAX_LEN];
  logic [CW-1:0]      slot_y_reg [MAX_LEN];

  logic signed [CW:0] dx, dy, sum_x, sum_y;
  logic               under_x, over_x, under_y, over_y;
  logic [CW-1:0]      head_x_next, head_y_next;
  logic               grow_eff;
  logic [MAX_LEN-1:0] hit_vec;
  logic               hit, kill, step_run, advance, enter_run, restart;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      default:   return DIR_NONE;
    endcase
  endfunction

  // Button priority and reversal lockout feeding the pending direction.
  always_comb begin
    req_dir = DIR_NONE;
    if (buttons[0])      req_dir = DIR_LEFT;
    else if (buttons[1]) req_dir = DIR_DOWN;
    else if (buttons[2]) req_dir = DIR_RIGHT;
    else if (buttons[3]) req_dir = DIR_UP;
    pend_next = pend_dir_reg;
    if (req_dir != DIR_NONE && !(len_reg > LEN_ONE && req_dir == opposite(dir_reg)))
      pend_next = req_dir;
  end

  always_comb begin
    dx = '0;
    dy = '0;
    case (pend_dir_reg)
      DIR_LEFT:  dx = VEL_NEG;
      DIR_RIGHT: dx = VEL_POS;
      DIR_UP:    dy = VEL_NEG;
      DIR_DOWN:  dy = VEL_POS;
      default:   ;
    endcase
  end

  assign sum_x   = $signed({1'b0, slot_x_reg[0]}) + dx;
  assign sum_y   = $signed({1'b0, slot_y_reg[0]}) + dy;
  assign under_x = sum_x[CW];
  assign under_y = sum_y[CW];
  assign over_x  = !sum_x[CW] && (sum_x >= LIM_X);
  assign over_y  = !sum_y[CW] && (sum_y >= LIM_Y);

  assign head_x_next = under_x ? LAST_X : (over_x ? '0 : sum_x[CW-1:0]);
  assign head_y_next = under_y ? LAST_Y : (over_y ? '0 : sum_y[CW-1:0]);

  assign grow_eff = grow_pend_reg | grow;
  assign len_next = (grow_eff && len_reg < LEN_MAX) ? len_reg + LEN_ONE : len_reg;

  // Post-shift slot gi holds the old slot gi-1; only slots below the new length can be hit.
  assign hit_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_hit
      assign hit_vec[gi] = (LW'(gi) < len_next) &&
                           (head_x_next == slot_x_reg[gi-1]) &&
                           (head_y_next == slot_y_reg[gi-1]);
    end
  endgenerate
  assign hit = |hit_vec;

`ifdef SNAKE_WALL_KILL_EN
  assign kill = hit | under_x | over_x | under_y | over_y;
`else
  assign kill = hit;
`endif

  assign step_run = (state_reg == ST_RUN) && step && (pend_dir_reg != DIR_NONE);
  assign advance  = step_run && !kill;

  always_comb begin
    state_next = state_reg;
    enter_run  = 1'b0;
    restart    = 1'b0;
    case (state_reg)
      ST_IDLE: if (start || |buttons) begin
        state_next = ST_RUN;
        enter_run  = 1'b1;
      end
      ST_RUN:  if (step_run && kill) state_next = ST_DEAD;
      ST_DEAD: if (start) begin
        state_next = ST_IDLE;
        restart    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_reg       <= DIR_NONE;
      pend_dir_reg  <= DIR_NONE;
      grow_pend_reg <= 1'b0;
      collision_reg <= 1'b0;
      len_reg       <= LEN_ONE;
      slot_x_reg[0] <= HOME_X;
      slot_y_reg[0] <= HOME_Y;
      for (int k = 1; k < MAX_LEN; k++) begin
        slot_x_reg[k] <= '0;
        slot_y_reg[k] <= '0;
      end
    end else if (restart) begin
      dir_reg       <= DIR_NONE;
      pend_dir_reg  <= DIR_NONE;
      grow_pend_reg <= 1'b0;
      collision_reg <= 1'b0;
      len_reg       <= LEN_ONE;
      slot_x_reg[0] <= HOME_X;
      slot_y_reg[0] <= HOME_Y;
      for (int k = 1; k < MAX_LEN; k++) begin
        slot_x_reg[k] <= '0;
        slot_y_reg[k] <= '0;
      end
    end else begin
      pend_dir_reg  <= pend_next;
      collision_reg <= step_run && kill;
      if (enter_run) dir_reg <= pend_next;
      if (state_reg == ST_RUN && grow) grow_pend_reg <= 1'b1;
      // A colliding step leaves positions, length and direction frozen.
      if (advance) begin
        dir_reg       <= pend_dir_reg;
        len_reg       <= len_next;
        grow_pend_reg <= 1'b0;
        slot_x_reg[0] <= head_x_next;
        slot_y_reg[0] <= head_y_next;
        for (int k = 1; k < MAX_LEN; k++) begin
          if (LW'(k) < len_next) begin
            slot_x_reg[k] <= slot_x_reg[k-1];
            slot_y_reg[k] <= slot_y_reg[k-1];
          end else begin
            slot_x_reg[k] <= '0;
            slot_y_reg[k] <= '0;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pack
      assign pos_x[gi*CW +: CW] = slot_x_reg[gi];
      assign pos_y[gi*CW +: CW] = slot_y_reg[gi];
    end
  endgenerate

  assign length    = len_reg;
  assign state     = state_reg;
  assign collision = collision_reg;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed testbench for snake_motion_engine: reset, movement, growth, lockout, collision, restart, wrap, async reset.
module tb_snake_motion_engine;
  localparam int CW      = 10;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [3:0]            buttons = 4'd0;
  logic                  step = 1'b0;
  logic                  grow = 1'b0;
  logic                  start = 1'b0;
  logic [MAX_LEN*CW-1:0] pos_x, pos_y;
  logic [LW-1:0]         length;
  logic [1:0]            state;
  logic                  collision;

  int errors = 0;
  int checks = 0;

  snake_motion_engine #(.GRID_W(640), .GRID_H(480), .CW(CW), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .step(step), .grow(grow), .start(start),
    .pos_x(pos_x), .pos_y(pos_y), .length(length), .state(state), .collision(collision)
  );

  always #5 clock = ~clock;

  function automatic logic [2*CW-1:0] xy(input int x, input int y);
    logic [CW-1:0] xs, ys;
    xs = x[CW-1:0];
    ys = y[CW-1:0];
    return {xs, ys};
  endfunction

  function automatic logic [2*CW-1:0] slot(input int k);
    return {pos_x[k*CW +: CW], pos_y[k*CW +: CW]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_step(input logic g);
    step = 1'b1;
    grow = g;
    tick();
    step = 1'b0;
    grow = 1'b0;
    $display("step grow=%0d: head=(%0d,%0d) len=%0d state=%0d coll=%0d",
             g, pos_x[CW-1:0], pos_y[CW-1:0], length, state, collision);
  endtask

  task automatic steps_n(input int n);
    for (int i = 0; i < n; i++) do_step(1'b0);
  endtask

  task automatic press(input logic [3:0] b);
    buttons = b;
    tick();
    buttons = 4'd0;
    $display("press %b: state=%0d", b, state);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start: state=%0d len=%0d", state, length);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    if (slot(0) !== xy(320, 240)) begin $display("FAIL reset_head: got %h want %h", slot(0), xy(320, 240)); errors++; end
    checks++;
    if (length !== 4'd1) begin $display("FAIL reset_length: got %0d want 1", length); errors++; end
    checks++;
    if (state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", state); errors++; end
    checks++;
    if (collision !== 1'b0) begin $display("FAIL reset_collision: got %0d want 0", collision); errors++; end
    checks++;
    if (slot(1) !== xy(0, 0)) begin $display("FAIL reset_slot1: got %h want %h", slot(1), xy(0, 0)); errors++; end
    checks++;
    do_step(1'b1);
    if (slot(0) !== xy(320, 240)) begin $display("FAIL idle_step_head: got %h want %h", slot(0), xy(320, 240)); errors++; end
    checks++;
    if (state !== 2'd0) begin $display("FAIL idle_step_state: got %0d want 0", state); errors++; end
    checks++;
    if (length !== 4'd1) begin $display("FAIL idle_grow_length: got %0d want 1", length); errors++; end
    checks++;
  endtask

  task automatic test_move_right();
    press(4'b0100);
    if (state !== 2'd1) begin $display("FAIL run_state: got %0d want 1", state); errors++; end
    checks++;
    for (int i = 1; i <= 3; i++) begin
      do_step(1'b0);
      if (slot(0) !== xy(320 + i, 240)) begin $display("FAIL right_head%0d: got %h want %h", i, slot(0), xy(320 + i, 240)); errors++; end
      checks++;
      if (slot(1) !== xy(0, 0)) begin $display("FAIL right_slot1_%0d: got %h want %h", i, slot(1), xy(0, 0)); errors++; end
      checks++;
    end
  endtask

  task automatic test_grow();
    for (int i = 0; i < 3; i++) begin
      grow = 1'b1;
      tick();
      grow = 1'b0;
      tick();
    end
    do_step(1'b0);
    if (length !== 4'd2) begin $display("FAIL grow_len2: got %0d want 2", length); errors++; end
    checks++;
    if (slot(0) !== xy(324, 240)) begin $display("FAIL grow_head2: got %h want %h", slot(0), xy(324, 240)); errors++; end
    checks++;
    if (slot(1) !== xy(323, 240)) begin $display("FAIL grow_slot1: got %h want %h", slot(1), xy(323, 240)); errors++; end
    checks++;
    if (slot(2) !== xy(0, 0)) begin $display("FAIL grow_slot2_zero: got %h want %h", slot(2), xy(0, 0)); errors++; end
    checks++;
    do_step(1'b1);
    if (length !== 4'd3) begin $display("FAIL grow_len3: got %0d want 3", length); errors++; end
    checks++;
    if (slot(2) !== xy(323, 240)) begin $display("FAIL grow_slot2: got %h want %h", slot(2), xy(323, 240)); errors++; end
    checks++;
    grow = 1'b1;
    tick();
    grow = 1'b0;
    do_step(1'b0);
    if (length !== 4'd4) begin $display("FAIL grow_len4: got %0d want 4", length); errors++; end
    checks++;
    if (slot(0) !== xy(326, 240)) begin $display("FAIL grow_head4: got %h want %h", slot(0), xy(326, 240)); errors++; end
    checks++;
    if (slot(3) !== xy(323, 240)) begin $display("FAIL grow_slot3: got %h want %h", slot(3), xy(323, 240)); errors++; end
    checks++;
    if (slot(4) !== xy(0, 0)) begin $display("FAIL grow_slot4_zero: got %h want %h", slot(4), xy(0, 0)); errors++; end
    checks++;
  endtask

  task automatic test_reversal_collision();
    press(4'b0001);
    do_step(1'b0);
    if (slot(0) !== xy(327, 240)) begin $display("FAIL lockout_head: got %h want %h", slot(0), xy(327, 240)); errors++; end
    checks++;
    press(4'b0010);
    do_step(1'b0);
    if (slot(0) !== xy(327, 241)) begin $display("FAIL down_head: got %h want %h", slot(0), xy(327, 241)); errors++; end
    checks++;
    press(4'b0001);
    do_step(1'b0);
    if (slot(0) !== xy(326, 241)) begin $display("FAIL left_head: got %h want %h", slot(0), xy(326, 241)); errors++; end
    checks++;
    // Growing on the up step makes the tail slot live, so the head lands on it.
    press(4'b1000);
    do_step(1'b1);
    if (state !== 2'd2) begin $display("FAIL coll_state: got %0d want 2", state); errors++; end
    checks++;
    if (collision !== 1'b1) begin $display("FAIL coll_pulse: got %0d want 1", collision); errors++; end
    checks++;
    if (slot(0) !== xy(326, 241)) begin $display("FAIL coll_head_frozen: got %h want %h", slot(0), xy(326, 241)); errors++; end
    checks++;
    if (length !== 4'd4) begin $display("FAIL coll_len_frozen: got %0d want 4", length); errors++; end
    checks++;
    if (slot(3) !== xy(326, 240)) begin $display("FAIL coll_slot3_frozen: got %h want %h", slot(3), xy(326, 240)); errors++; end
    checks++;
    tick();
    if (collision !== 1'b0) begin $display("FAIL coll_one_cycle: got %0d want 0", collision); errors++; end
    checks++;
  endtask

  task automatic test_dead_restart();
    do_step(1'b0);
    if (slot(0) !== xy(326, 241)) begin $display("FAIL dead_step_hold: got %h want %h", slot(0), xy(326, 241)); errors++; end
    checks++;
    pulse_start();
    if (state !== 2'd0) begin $display("FAIL restart_state: got %0d want 0", state); errors++; end
    checks++;
    if (slot(0) !== xy(320, 240)) begin $display("FAIL restart_head: got %h want %h", slot(0), xy(320, 240)); errors++; end
    checks++;
    if (length !== 4'd1) begin $display("FAIL restart_len: got %0d want 1", length); errors++; end
    checks++;
    if (slot(3) !== xy(0, 0)) begin $display("FAIL restart_slot3: got %h want %h", slot(3), xy(0, 0)); errors++; end
    checks++;
  endtask

  task automatic test_wrap();
    grow = 1'b1;
    tick();
    grow = 1'b0;
    press(4'b1000);
    do_step(1'b0);
    if (length !== 4'd1) begin $display("FAIL idle_grow_dropped: got %0d want 1", length); errors++; end
    checks++;
    steps_n(139);
    if (slot(0) !== xy(320, 100)) begin $display("FAIL up_to_100: got %h want %h", slot(0), xy(320, 100)); errors++; end
    checks++;
    pulse_start();
    if (state !== 2'd1) begin $display("FAIL start_in_run: got %0d want 1", state); errors++; end
    checks++;
    press(4'b0001);
    steps_n(320);
    if (slot(0) !== xy(0, 100)) begin $display("FAIL left_to_0: got %h want %h", slot(0), xy(0, 100)); errors++; end
    checks++;
    do_step(1'b0);
`ifdef SNAKE_WALL_KILL_EN
    if (state !== 2'd2) begin $display("FAIL wall_state: got %0d want 2", state); errors++; end
    checks++;
    if (collision !== 1'b1) begin $display("FAIL wall_pulse: got %0d want 1", collision); errors++; end
    checks++;
    if (slot(0) !== xy(0, 100)) begin $display("FAIL wall_head_frozen: got %h want %h", slot(0), xy(0, 100)); errors++; end
    checks++;
    pulse_start();
    press(4'b0100);
`else
    if (slot(0) !== xy(639, 100)) begin $display("FAIL wrap_left: got %h want %h", slot(0), xy(639, 100)); errors++; end
    checks++;
    if (state !== 2'd1) begin $display("FAIL wrap_state: got %0d want 1", state); errors++; end
    checks++;
    press(4'b0100);
    do_step(1'b0);
    if (slot(0) !== xy(0, 100)) begin $display("FAIL wrap_right: got %h want %h", slot(0), xy(0, 100)); errors++; end
    checks++;
    press(4'b1000);
    steps_n(100);
    do_step(1'b0);
    if (slot(0) !== xy(0, 479)) begin $display("FAIL wrap_up: got %h want %h", slot(0), xy(0, 479)); errors++; end
    checks++;
    press(4'b0010);
    do_step(1'b0);
    if (slot(0) !== xy(0, 0)) begin $display("FAIL wrap_down: got %h want %h", slot(0), xy(0, 0)); errors++; end
    checks++;
`endif
  endtask

  task automatic test_reset_mid_run();
    do_step(1'b1);
    if (length !== 4'd2) begin $display("FAIL pre_reset_len: got %0d want 2", length); errors++; end
    checks++;
    #3;
    reset = 1'b0;
    #1;
    if (state !== 2'd0) begin $display("FAIL async_state: got %0d want 0", state); errors++; end
    checks++;
    if (length !== 4'd1) begin $display("FAIL async_len: got %0d want 1", length); errors++; end
    checks++;
    if (slot(0) !== xy(320, 240)) begin $display("FAIL async_head: got %h want %h", slot(0), xy(320, 240)); errors++; end
    checks++;
    if (slot(1) !== xy(0, 0)) begin $display("FAIL async_slot1: got %h want %h", slot(1), xy(0, 0)); errors++; end
    checks++;
    tick();
    reset = 1'b1;
    tick();
    if (state !== 2'd0) begin $display("FAIL post_reset_state: got %0d want 0", state); errors++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_grow();
    test_reversal_collision();
    test_dead_restart();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
